button_debounce: RTL and testbench
==================================

// Module: button_debounce
// PURPOSE
//  Front-end conditioning for user push-buttons. Sits directly upstream of the single-pulse stage, feeding its ub input.
//  Synchronises the raw asynchronous pin and rejects contact bounce with a stability counter.
//  Outputs a clean level (ub_clean) plus registered rise/fall strobes.
//  Also outputs a saturating count of rejected bounces for debug readback.
// PARAMETERS
//  SYNC_STAGES      2       synchroniser depth (flops); legal >= 2
//  DEBOUNCE_CYCLES  500000  consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal >= 2
//  IN_ACTIVE_LOW    0       1 = pin reads 0 when pressed; inverted after synchroniser so ub_clean=1 means pressed
//  CNT_W            20      width of stability counter; must satisfy 2**CNT_W >= DEBOUNCE_CYCLES
// PORTS
//  clk         in   1  system clock
//  rst_l       in   1  asynchronous, active-low reset
//  ub_raw      in   1  raw button pin, asynchronous to clk
//  bounce_clr  in   1  synchronous clear of bounce_cnt
//  ub_clean    out  1  debounced level, registered
//  ub_rise     out  1  one-cycle strobe, same cycle ub_clean goes 0->1
//  ub_fall     out  1  one-cycle strobe, same cycle ub_clean goes 1->0
//  bounce_cnt  out  8  rejected-transition count, saturates at 255
// BEHAVIOUR
//  Reset (async assert, sync-free deassert):
//  - Synchroniser flops load IN_ACTIVE_LOW, so the internal level s = 0.
//  - State = ST_LOW, stability counter = 0, ub_clean/ub_rise/ub_fall = 0, bounce_cnt = 0.
//  - Reset mid-debounce abandons the check immediately; no strobe is emitted.
//  s = last synchroniser flop XOR IN_ACTIVE_LOW.
//  FSM, evaluated each posedge clk:
//   ST_LOW    : s=1 -> ST_CHK_HI, cnt<=0; else stay.
//   ST_CHK_HI : s=0 -> ST_LOW, bounce_cnt++.
//               s=1 and cnt==DEBOUNCE_CYCLES-1 -> ST_HIGH, ub_clean<=1, ub_rise<=1.
//               otherwise cnt++.
//   ST_HIGH   : s=0 -> ST_CHK_LO, cnt<=0; else stay.
//   ST_CHK_LO : mirror of ST_CHK_HI with the levels swapped:
//               s=1 -> ST_HIGH, bounce_cnt++.
//               s=0 and cnt==DEBOUNCE_CYCLES-1 -> ST_LOW, ub_clean<=0, ub_fall<=1.
//               otherwise cnt++.
//  Latency:
//  - From the first clk edge that samples a stable new ub_raw level to the ub_clean change: exactly
//    SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
//  - A level held for fewer than that is rejected and counted.
//  Strobes:
//  - ub_rise/ub_fall are high for exactly one cycle and are never both high.
//  - Each ub_clean edge produces exactly one strobe.
//  bounce_cnt:
//  - Saturates at 8'hFF and never wraps.
//  - bounce_clr forces 0 on the next edge and wins over a simultaneous increment.
//  Downstream guarantee:
//  - ub_clean stays low >= DEBOUNCE_CYCLES+1 cycles between a fall and the next rise, so the single-pulse
//    stage's minimum-gap requirement (>= 2 cycles) always holds.
//  - ub_clean is glitch-free because it is driven straight from a flop.
//  cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap; unused state encodings recover to ST_LOW.
// STRUCTURE
//  - Shared include ub_pkg.vh holds the state encodings ST_LOW=2'd0, ST_CHK_HI=2'd1, ST_HIGH=2'd2, ST_CHK_LO=2'd3
//    and the BOUNCE_MAX=8'hFF constant.
//  - Sub-module sync_ff_chain (params STAGES, RST_VAL) is reused by other asynchronous inputs.
//  - FSM, stability counter, strobes and bounce counter live in this module.
// TESTING (bench params: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, IN_ACTIVE_LOW=0)
//  1. ub_raw 0->1, held -> ub_clean=1 and ub_rise=1 on the 7th edge after first sampled; ub_rise low the next cycle.
//  2. ub_raw high for 3 cycles, then low -> ub_clean stays 0, no strobes, bounce_cnt=1.
//  3. From ub_clean=1, ub_raw 1->0 held -> ub_clean=0 and ub_fall=1 on the 7th edge; ub_rise stays 0 throughout.
//  4. 300 short 2-cycle pulses -> bounce_cnt=255 (saturated); then bounce_clr together with one more bounce -> bounce_cnt=0.
//  5. rst_l low while in ST_CHK_HI with cnt=2 -> all outputs 0 immediately; no ub_rise after release while ub_raw=0.
//  6. IN_ACTIVE_LOW=1: reset with ub_raw=1 -> ub_clean=0; ub_raw held at 0 -> ub_clean=1 after 7 edges.

Source files
------------

// File: rtl/button_debounce_pkg.sv
// Shared encodings and constants for the push-button debouncer.
package button_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } state_t;

    localparam logic [7:0] BOUNCE_MAX = 8'hFF;

    // Saturating increment: the debug counter holds at BOUNCE_MAX instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == BOUNCE_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/button_debounce_sync_ff_chain.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
module button_debounce_sync_ff_chain #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_l,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Reset loads the idle pin level so no false edge appears on reset release.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_sync <= {STAGES{RST_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronise, debounce with a stability counter,
// emit a clean level, rise/fall strobes and a saturating bounce count.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit IN_ACTIVE_LOW   = 1'b0,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       ub_raw,
    input  logic       bounce_clr,
    output logic       ub_clean,
    output logic       ub_rise,
    output logic       ub_fall,
    output logic [7:0] bounce_cnt
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_sync_q;
    logic             w_s;
    logic             w_cnt_done;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clean;
    logic             w_clean_nxt;
    logic             r_rise;
    logic             w_rise_nxt;
    logic             r_fall;
    logic             w_fall_nxt;
    logic [7:0]       r_bounce;
    logic [7:0]       w_bounce_nxt;
    logic             w_bounce_inc;

    button_debounce_sync_ff_chain #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IN_ACTIVE_LOW)
    ) u_sync (
        .clk   (clk),
        .rst_l (rst_l),
        .i_d   (ub_raw),
        .o_q   (w_sync_q)
    );

    // Normalise polarity so w_s = 1 always means "pressed".
    assign w_s        = w_sync_q ^ IN_ACTIVE_LOW;
    assign w_cnt_done = (r_cnt == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state  <= ST_LOW;
            r_cnt    <= '0;
            r_clean  <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_bounce <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_clean  <= w_clean_nxt;
            r_rise   <= w_rise_nxt;
            r_fall   <= w_fall_nxt;
            r_bounce <= w_bounce_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOW: begin
                if (w_s) w_state_nxt = ST_CHK_HI;
            end
            ST_CHK_HI: begin
                if (!w_s)           w_state_nxt = ST_LOW;
                else if (w_cnt_done) w_state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
                if (!w_s) w_state_nxt = ST_CHK_LO;
            end
            ST_CHK_LO: begin
                if (w_s)            w_state_nxt = ST_HIGH;
                else if (w_cnt_done) w_state_nxt = ST_LOW;
            end
            default: w_state_nxt = ST_LOW;
        endcase
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_clean_nxt  = r_clean;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_bounce_inc = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_s) w_cnt_nxt = '0;
            end
            ST_CHK_HI: begin
                if (!w_s) begin
                    w_bounce_inc = 1'b1;
                end else if (w_cnt_done) begin
                    w_clean_nxt = 1'b1;
                    w_rise_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (!w_s) w_cnt_nxt = '0;
            end
            ST_CHK_LO: begin
                if (w_s) begin
                    w_bounce_inc = 1'b1;
                end else if (w_cnt_done) begin
                    w_clean_nxt = 1'b0;
                    w_fall_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_clean_nxt = 1'b0;
            end
        endcase

        // Clear has priority over a coincident rejected bounce.
        if (bounce_clr)        w_bounce_nxt = '0;
        else if (w_bounce_inc) w_bounce_nxt = sat_inc(r_bounce);
        else                   w_bounce_nxt = r_bounce;
    end

    assign ub_clean   = r_clean;
    assign ub_rise    = r_rise;
    assign ub_fall    = r_fall;
    assign bounce_cnt = r_bounce;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: run-length reference model checked every cycle plus directed literal checks.
module tb_button_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;

    logic       clk         = 1'b0;
    logic       rst_l       = 1'b0;
    logic       ub_raw      = 1'b0;
    logic       bounce_clr  = 1'b0;
    logic       ub_raw2     = 1'b1;
    logic       bounce_clr2 = 1'b0;

    logic       clean0, rise0, fall0;
    logic [7:0] bcnt0;
    logic       clean1, rise1, fall1;
    logic [7:0] bcnt1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    button_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .IN_ACTIVE_LOW(1'b0), .CNT_W(20)
    ) u_dut (
        .clk(clk), .rst_l(rst_l), .ub_raw(ub_raw), .bounce_clr(bounce_clr),
        .ub_clean(clean0), .ub_rise(rise0), .ub_fall(fall0), .bounce_cnt(bcnt0)
    );

    button_debounce #(
        .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .IN_ACTIVE_LOW(1'b1), .CNT_W(20)
    ) u_dut_al (
        .clk(clk), .rst_l(rst_l), .ub_raw(ub_raw2), .bounce_clr(bounce_clr2),
        .ub_clean(clean1), .ub_rise(rise1), .ub_fall(fall1), .bounce_cnt(bcnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a level change is accepted once the synchronised pin has
    // disagreed with the clean level for DEB+1 consecutive edges; an interrupted
    // run counts as one rejected bounce.
    logic m_hist  [2][SYNC];
    int   m_run   [2];
    logic m_clean [2];
    logic m_rise  [2];
    logic m_fall  [2];
    int   m_bounce[2];

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < SYNC; k++) m_hist[i][k] = 1'b0;
            m_run[i]    = 0;
            m_clean[i]  = 1'b0;
            m_rise[i]   = 1'b0;
            m_fall[i]   = 1'b0;
            m_bounce[i] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic s_in, input logic clr);
        logic s_seen;
        logic inc;
        s_seen = m_hist[i][SYNC-1];
        for (int k = SYNC-1; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = s_in;
        m_rise[i] = 1'b0;
        m_fall[i] = 1'b0;
        inc = 1'b0;
        if (s_seen != m_clean[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB + 1) begin
                m_clean[i] = s_seen;
                if (s_seen) m_rise[i] = 1'b1;
                else        m_fall[i] = 1'b1;
                m_run[i] = 0;
            end
        end else begin
            inc = (m_run[i] > 0);
            m_run[i] = 0;
        end
        if (clr)                          m_bounce[i] = 0;
        else if (inc && m_bounce[i] < 255) m_bounce[i]++;
    endtask

    // Inputs as seen by the DUT at each rising edge, consumed by the model half a cycle later.
    logic smp_rst  = 1'b0;
    logic smp_raw0 = 1'b0;
    logic smp_clr0 = 1'b0;
    logic smp_raw1 = 1'b1;
    logic smp_clr1 = 1'b0;

    always @(posedge clk) begin
        smp_rst  <= rst_l;
        smp_raw0 <= ub_raw;
        smp_clr0 <= bounce_clr;
        smp_raw1 <= ub_raw2;
        smp_clr1 <= bounce_clr2;
    end

    always @(negedge clk) begin
        if (!rst_l || !smp_rst) begin
            model_reset();
        end else begin
            model_edge(0, smp_raw0, smp_clr0);
            model_edge(1, smp_raw1 ^ 1'b1, smp_clr1);
        end
        check("cyc_clean0", clean0, m_clean[0]);
        check("cyc_rise0",  rise0,  m_rise[0]);
        check("cyc_fall0",  fall0,  m_fall[0]);
        check("cyc_bcnt0",  bcnt0,  m_bounce[0]);
        check("cyc_clean1", clean1, m_clean[1]);
        check("cyc_rise1",  rise1,  m_rise[1]);
        check("cyc_fall1",  fall1,  m_fall[1]);
        check("cyc_bcnt1",  bcnt1,  m_bounce[1]);
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        step(3);
        check("rst_clean", clean0, 0);
        check("rst_rise",  rise0,  0);
        check("rst_bcnt",  bcnt0,  0);
        rst_l = 1'b1;
        step(2);

        // Short 3-cycle high is rejected and counted
        ub_raw = 1'b1;
        step(3);
        ub_raw = 1'b0;
        step(6);
        check("short_clean", clean0, 0);
        check("short_bcnt",  bcnt0,  1);

        // Held press: clean rises on the 7th edge with a one-cycle rise strobe
        ub_raw = 1'b1;
        step(6);
        check("rise_edge6_clean", clean0, 0);
        step(1);
        check("rise_edge7_clean", clean0, 1);
        check("rise_edge7_rise",  rise0,  1);
        check("rise_edge7_fall",  fall0,  0);
        step(1);
        check("rise_after_rise",  rise0,  0);
        check("rise_after_clean", clean0, 1);

        // Held release: clean falls on the 7th edge with a one-cycle fall strobe
        ub_raw = 1'b0;
        step(6);
        check("fall_edge6_clean", clean0, 1);
        step(1);
        check("fall_edge7_clean", clean0, 0);
        check("fall_edge7_fall",  fall0,  1);
        check("fall_edge7_rise",  rise0,  0);
        step(1);
        check("fall_after_fall",  fall0,  0);

        // Reset while in ST_CHK_HI with cnt=2
        ub_raw = 1'b1;
        step(5);
        check("pre_rst_bcnt", bcnt0, 1);
        #2 rst_l = 1'b0;
        #1;
        check("midrst_clean", clean0, 0);
        check("midrst_rise",  rise0,  0);
        check("midrst_fall",  fall0,  0);
        check("midrst_bcnt",  bcnt0,  0);
        ub_raw = 1'b0;
        step(1);
        rst_l = 1'b1;
        step(10);
        check("postrst_clean", clean0, 0);
        check("postrst_rise",  rise0,  0);

        // Bounce counter saturation
        for (int p = 0; p < 300; p++) begin
            ub_raw = 1'b1;
            step(2);
            ub_raw = 1'b0;
            step(3);
            if (p == 253) check("sat_bcnt_254", bcnt0, 254);
        end
        check("sat_bcnt_255", bcnt0, 255);
        check("sat_clean",    clean0, 0);

        // Clear wins over a coincident rejected bounce
        bounce_clr = 1'b1;
        ub_raw = 1'b1;
        step(2);
        ub_raw = 1'b0;
        step(3);
        bounce_clr = 1'b0;
        step(1);
        check("clr_bcnt", bcnt0, 0);

        // Active-low instance: idle pin high reads as released, low held reads as pressed
        #2 rst_l = 1'b0;
        #1;
        check("al_rst_clean", clean1, 0);
        step(1);
        rst_l = 1'b1;
        step(2);
        check("al_idle_clean", clean1, 0);
        ub_raw2 = 1'b0;
        step(6);
        check("al_edge6_clean", clean1, 0);
        step(1);
        check("al_edge7_clean", clean1, 1);
        check("al_edge7_rise",  rise1,  1);
        step(1);
        check("al_after_rise",  rise1,  0);
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
